writeback_stage: RTL and testbench

- Final MIPS pipeline stage. Registers the MEM/WB boundary, formats load data, and selects the write-back value.
- Drives the register-file write port of the decode stage: reg_write, write_register, data_rw.
- Suppresses writes to $zero, tracks retired instructions, and latches pipeline-drained halt status for the debug/host side.

---
 rtl/writeback_stage_pkg.sv | 29 ++
 rtl/writeback_stage_load_formatter.sv | 45 ++++
 rtl/writeback_stage.sv | 123 ++++++++++++
 tb/tb_writeback_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the write-back stage: mem_to_reg selector codes,
// load size codes and the bit positions inside the wb / load_type fields.
package wb_defs;

    // Write-back value source, taken from wb_signals[1:0].
    // The reserved code falls back to the ALU result.
    typedef enum logic [1:0] {
        MEMTOREG_ALU  = 2'b00,
        MEMTOREG_MEM  = 2'b01,
        MEMTOREG_LINK = 2'b10,
        MEMTOREG_RSVD = 2'b11
    } mem_to_reg_e;

    // Load access size, taken from load_type[1:0].
    // The reserved code is treated as a full word.
    typedef enum logic [1:0] {
        LOAD_BYTE = 2'b00,
        LOAD_HALF = 2'b01,
        LOAD_RSVD = 2'b10,
        LOAD_WORD = 2'b11
    } load_size_e;

    // load_type[LOAD_UNSIGNED] selects zero-extension instead of sign-extension.
    localparam int LOAD_UNSIGNED   = 2;

    // wb_signals[WB_REGWRITE_BIT] is the register-file write request.
    localparam int WB_REGWRITE_BIT = 2;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Little-endian load formatter: extracts the addressed byte/half from the raw
// memory word and sign- or zero-extends it. Purely combinational so it can
// also be reused on a forwarding path.
module load_formatter
    import wb_defs::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] mem_data_i,
    input  logic [2:0]         load_type_i,
    input  logic [1:0]         addr_lsb_i,
    output logic [NB_DATA-1:0] formatted_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;
    load_size_e  w_size;

    // Select the addressed lane; byte k lives at mem_data[8k+7:8k].
    always_comb begin
        w_unsigned = load_type_i[LOAD_UNSIGNED];
        w_size     = load_size_e'(load_type_i[1:0]);
        case (addr_lsb_i)
            2'd0:    w_byte = mem_data_i[7:0];
            2'd1:    w_byte = mem_data_i[15:8];
            2'd2:    w_byte = mem_data_i[23:16];
            default: w_byte = mem_data_i[31:24];
        endcase
        // addr_lsb[0] is ignored for halfwords.
        w_half = addr_lsb_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    end

    // Extend the selected lane to the datapath width.
    always_comb begin
        case (w_size)
            LOAD_BYTE: formatted_o = w_unsigned ? {{(NB_DATA-8){1'b0}}, w_byte}
                                                : {{(NB_DATA-8){w_byte[7]}}, w_byte};
            LOAD_HALF: formatted_o = w_unsigned ? {{(NB_DATA-16){1'b0}}, w_half}
                                                : {{(NB_DATA-16){w_half[15]}}, w_half};
            default:   formatted_o = mem_data_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, load formatting, write-back mux,
// $zero write suppression, sticky halt status and retired-instruction count.
// The register loads when enable_i=1 (flush_i forces a bubble); there is no
// back-pressure, enable_i low simply holds the slot and repeats its outputs.
module writeback_stage
    import wb_defs::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [2:0]         wb_signals_i,
    input  logic [2:0]         load_type_i,
    input  logic [1:0]         addr_lsb_i,
    input  logic [NB_DATA-1:0] mem_data_i,
    input  logic [NB_DATA-1:0] alu_result_i,
    input  logic [NB_DATA-1:0] pc_link_i,
    input  logic [NB_REG-1:0]  write_register_i,
    input  logic               halt_i,
    output logic               reg_write_o,
    output logic [NB_REG-1:0]  write_register_o,
    output logic [NB_DATA-1:0] data_rw_o,
    output logic               halt_done_o,
    output logic [NB_CNT-1:0]  retired_count_o
);

    // MEM/WB register fields
    logic               r_valid;
    logic [2:0]         r_wb;
    logic [2:0]         r_load_type;
    logic [1:0]         r_addr_lsb;
    logic [NB_DATA-1:0] r_mem_data;
    logic [NB_DATA-1:0] r_alu_result;
    logic [NB_DATA-1:0] r_pc_link;
    logic [NB_REG-1:0]  r_write_register;
    logic               r_halt;

    // Status
    logic               r_halt_done;
    logic [NB_CNT-1:0]  r_retired_count;

    logic               w_load_slot;
    logic               w_halt_in_wb;
    logic [NB_DATA-1:0] w_load_data;

    assign w_load_slot  = enable_i & ~flush_i;
    assign w_halt_in_wb = r_valid & r_halt;

    // Pipeline register: reset > flush (bubble) > enable (load) > hold.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            r_valid          <= 1'b0;
            r_wb             <= '0;
            r_load_type      <= '0;
            r_addr_lsb       <= '0;
            r_mem_data       <= '0;
            r_alu_result     <= '0;
            r_pc_link        <= '0;
            r_write_register <= '0;
            r_halt           <= 1'b0;
        end else if (enable_i) begin
            r_valid          <= valid_i;
            r_wb             <= wb_signals_i;
            r_load_type      <= load_type_i;
            r_addr_lsb       <= addr_lsb_i;
            r_mem_data       <= mem_data_i;
            r_alu_result     <= alu_result_i;
            r_pc_link        <= pc_link_i;
            r_write_register <= write_register_i;
            r_halt           <= halt_i;
        end
    end

    // Sticky halt flag: set on the edge after a valid HALT sits in WB.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_halt_done <= 1'b0;
        end else if (w_halt_in_wb) begin
            r_halt_done <= 1'b1;
        end
    end

    // Retired counter. The HALT slot itself counts, but the instruction that
    // enters on the same edge halt_done sets is already behind HALT, so a HALT
    // sitting in WB freezes the count just like halt_done does.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_retired_count <= '0;
        end else if (w_load_slot && valid_i && !r_halt_done && !w_halt_in_wb) begin
            r_retired_count <= r_retired_count + NB_CNT'(1);
        end
    end

    load_formatter #(
        .NB_DATA (NB_DATA)
    ) u_load_formatter (
        .mem_data_i  (r_mem_data),
        .load_type_i (r_load_type),
        .addr_lsb_i  (r_addr_lsb),
        .formatted_o (w_load_data)
    );

    // Write-back value mux and write enable, all from registered fields.
    always_comb begin
        case (mem_to_reg_e'(r_wb[1:0]))
            MEMTOREG_MEM:  data_rw_o = w_load_data;
            MEMTOREG_LINK: data_rw_o = r_pc_link;
            default:       data_rw_o = r_alu_result;
        endcase
        reg_write_o = r_valid & r_wb[WB_REGWRITE_BIT] &
                      (r_write_register != '0) & ~r_halt_done;
    end

    assign write_register_o = r_write_register;
    assign halt_done_o      = r_halt_done;
    assign retired_count_o  = r_retired_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: one task per feature, inline checks,
// expected values computed by hand from the stage's documented behaviour.
module tb_writeback_stage;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        flush_i;
    logic        valid_i;
    logic [2:0]  wb_signals_i;
    logic [2:0]  load_type_i;
    logic [1:0]  addr_lsb_i;
    logic [31:0] mem_data_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_link_i;
    logic [4:0]  write_register_i;
    logic        halt_i;
    logic        reg_write_o;
    logic [4:0]  write_register_o;
    logic [31:0] data_rw_o;
    logic        halt_done_o;
    logic [31:0] retired_count_o;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_cnt;

    writeback_stage dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .enable_i         (enable_i),
        .flush_i          (flush_i),
        .valid_i          (valid_i),
        .wb_signals_i     (wb_signals_i),
        .load_type_i      (load_type_i),
        .addr_lsb_i       (addr_lsb_i),
        .mem_data_i       (mem_data_i),
        .alu_result_i     (alu_result_i),
        .pc_link_i        (pc_link_i),
        .write_register_i (write_register_i),
        .halt_i           (halt_i),
        .reg_write_o      (reg_write_o),
        .write_register_o (write_register_o),
        .data_rw_o        (data_rw_o),
        .halt_done_o      (halt_done_o),
        .retired_count_o  (retired_count_o)
    );

    // Clock
    always #5 clock_i = ~clock_i;

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Present one slot with enable=1, flush=0.
    task automatic drive(input logic v, input logic [2:0] wb, input logic [2:0] lt,
                         input logic [1:0] lsb, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [31:0] link,
                         input logic [4:0] rd, input logic h);
        enable_i = 1'b1; flush_i = 1'b0; valid_i = v; wb_signals_i = wb;
        load_type_i = lt; addr_lsb_i = lsb; mem_data_i = mem; alu_result_i = alu;
        pc_link_i = link; write_register_i = rd; halt_i = h;
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        drive(1'b1, 3'b100, 3'b011, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd9, 1'b0);
        tick();
        tick();
        tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rw got %b exp 0", reg_write_o); end
        tests_run++; if (write_register_o !== 5'd0) begin tests_failed++; $display("FAIL reset_rd got %0d exp 0", write_register_o); end
        tests_run++; if (data_rw_o !== 32'h0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", data_rw_o); end
        tests_run++; if (halt_done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_halt got %b exp 0", halt_done_o); end
        tests_run++; if (retired_count_o !== 32'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d exp 0", retired_count_o); end
        reset_i = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_load_byte();
        // lbu, addr 2 of 0x80FF7F01 -> 0xFF
        drive(1'b1, 3'b101, 3'b100, 2'd2, 32'h80FF_7F01, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (reg_write_o !== 1'b1) begin tests_failed++; $display("FAIL lbu_rw got %b exp 1", reg_write_o); end
        tests_run++; if (write_register_o !== 5'd5) begin tests_failed++; $display("FAIL lbu_rd got %0d exp 5", write_register_o); end
        tests_run++; if (data_rw_o !== 32'h0000_00FF) begin tests_failed++; $display("FAIL lbu_data got %h exp 000000ff", data_rw_o); end
        tests_run++; if (retired_count_o !== exp_cnt) begin tests_failed++; $display("FAIL lbu_cnt got %0d exp %0d", retired_count_o, exp_cnt); end
        // lb, same byte -> sign-extended
        drive(1'b1, 3'b101, 3'b000, 2'd2, 32'h80FF_7F01, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL lb_data got %h exp ffffffff", data_rw_o); end
        // lb addr 1 -> 0x7F positive
        drive(1'b1, 3'b101, 3'b000, 2'd1, 32'h80FF_7F01, 32'hDEAD_BEEF, 32'h0, 5'd6, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'h0000_007F) begin tests_failed++; $display("FAIL lb_pos_data got %h exp 0000007f", data_rw_o); end
        tests_run++; if (retired_count_o !== exp_cnt) begin tests_failed++; $display("FAIL lb_cnt got %0d exp %0d", retired_count_o, exp_cnt); end
    endtask

    task automatic test_load_half();
        // lh, addr 3 -> upper half 0x80FF, sign-extended
        drive(1'b1, 3'b101, 3'b001, 2'd3, 32'h80FF_7F01, 32'h0, 32'h0, 5'd5, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'hFFFF_80FF) begin tests_failed++; $display("FAIL lh_data got %h exp ffff80ff", data_rw_o); end
        drive(1'b1, 3'b101, 3'b101, 2'd3, 32'h80FF_7F01, 32'h0, 32'h0, 5'd5, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'h0000_80FF) begin tests_failed++; $display("FAIL lhu_data got %h exp 000080ff", data_rw_o); end
        // lh addr 1 -> lower half 0x7F01
        drive(1'b1, 3'b101, 3'b001, 2'd1, 32'h80FF_7F01, 32'h0, 32'h0, 5'd5, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'h0000_7F01) begin tests_failed++; $display("FAIL lh_lo_data got %h exp 00007f01", data_rw_o); end
    endtask

    task automatic test_load_word();
        // reserved size 10 behaves as word; addr ignored
        drive(1'b1, 3'b101, 3'b010, 2'd1, 32'h80FF_7F01, 32'h0, 32'h0, 5'd9, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'h80FF_7F01) begin tests_failed++; $display("FAIL lw_data got %h exp 80ff7f01", data_rw_o); end
        // reserved mem_to_reg 11 selects ALU
        drive(1'b1, 3'b111, 3'b011, 2'd0, 32'h80FF_7F01, 32'h0BAD_F00D, 32'h0, 5'd9, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (data_rw_o !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL rsvd_sel_data got %h exp 0badf00d", data_rw_o); end
    endtask

    task automatic test_link();
        drive(1'b1, 3'b110, 3'b011, 2'd0, 32'h0, 32'h1234_5678, 32'h0000_0048, 5'd31, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (reg_write_o !== 1'b1) begin tests_failed++; $display("FAIL jal_rw got %b exp 1", reg_write_o); end
        tests_run++; if (write_register_o !== 5'd31) begin tests_failed++; $display("FAIL jal_rd got %0d exp 31", write_register_o); end
        tests_run++; if (data_rw_o !== 32'h0000_0048) begin tests_failed++; $display("FAIL jal_data got %h exp 00000048", data_rw_o); end
        // destination $zero: no write, still retires
        drive(1'b1, 3'b110, 3'b011, 2'd0, 32'h0, 32'h1234_5678, 32'h0000_0048, 5'd0, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL jal_r0_rw got %b exp 0", reg_write_o); end
        tests_run++; if (data_rw_o !== 32'h0000_0048) begin tests_failed++; $display("FAIL jal_r0_data got %h exp 00000048", data_rw_o); end
        tests_run++; if (retired_count_o !== exp_cnt) begin tests_failed++; $display("FAIL jal_r0_cnt got %0d exp %0d", retired_count_o, exp_cnt); end
        // invalid slot with reg_write set: no write, no retire
        drive(1'b0, 3'b100, 3'b011, 2'd0, 32'h0, 32'h5555_5555, 32'h0, 5'd4, 1'b0);
        tick();
        tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL invalid_rw got %b exp 0", reg_write_o); end
        tests_run++; if (retired_count_o !== exp_cnt) begin tests_failed++; $display("FAIL invalid_cnt got %0d exp %0d", retired_count_o, exp_cnt); end
    endtask

    task automatic test_flush();
        drive(1'b1, 3'b101, 3'b011, 2'd0, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0, 5'd5, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL flush_rw got %b exp 0", reg_write_o); end
        tests_run++; if (write_register_o !== 5'd0) begin tests_failed++; $display("FAIL flush_rd got %0d exp 0", write_register_o); end
        tests_run++; if (data_rw_o !== 32'h0) begin tests_failed++; $display("FAIL flush_data got %h exp 0", data_rw_o); end
        tests_run++; if (retired_count_o !== exp_cnt) begin tests_failed++; $display("FAIL flush_cnt got %0d exp %0d", retired_count_o, exp_cnt); end
    endtask

    task automatic test_hold();
        drive(1'b1, 3'b100, 3'b011, 2'd0, 32'h0, 32'h0000_1234, 32'h0, 5'd7, 1'b0);
        tick(); exp_cnt++;
        tests_run++; if (reg_write_o !== 1'b1) begin tests_failed++; $display("FAIL hold_load_rw got %b exp 1", reg_write_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b110, 3'b000, 2'd3, 32'hFFFF_FFFF, 32'h9999_0000 + i, 32'h44, 5'd12, 1'b0);
            enable_i = 1'b0;
            tick();
            tests_run++; if (reg_write_o !== 1'b1) begin tests_failed++; $display("FAIL hold_rw[%0d] got %b exp 1", i, reg_write_o); end
            tests_run++; if (write_register_o !== 5'd7) begin tests_failed++; $display("FAIL hold_rd[%0d] got %0d exp 7", i, write_register_o); end
            tests_run++; if (data_rw_o !== 32'h0000_1234) begin tests_failed++; $display("FAIL hold_data[%0d] got %h exp 00001234", i, data_rw_o); end
            tests_run++; if (retired_count_o !== exp_cnt) begin tests_failed++; $display("FAIL hold_cnt[%0d] got %0d exp %0d", i, retired_count_o, exp_cnt); end
        end
        enable_i = 1'b1;
    endtask

    task automatic test_halt_stream();
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'b100, 3'b011, 2'd0, 32'h0, 32'h100 + i, 32'h0, 5'(i), 1'b0);
            tick(); exp_cnt++;
            tests_run++; if (reg_write_o !== 1'b1) begin tests_failed++; $display("FAIL stream_rw[%0d] got %b exp 1", i, reg_write_o); end
            tests_run++; if (data_rw_o !== 32'h100 + i) begin tests_failed++; $display("FAIL stream_data[%0d] got %h exp %h", i, data_rw_o, 32'h100 + i); end
        end
        drive(1'b1, 3'b000, 3'b011, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
        tick(); exp_cnt++;
        tests_run++; if (halt_done_o !== 1'b0) begin tests_failed++; $display("FAIL halt_in_wb_done got %b exp 0", halt_done_o); end
        tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL halt_in_wb_rw got %b exp 0", reg_write_o); end
        tests_run++; if (retired_count_o !== 32'd5) begin tests_failed++; $display("FAIL halt_in_wb_cnt got %0d exp 5", retired_count_o); end
        for (int i = 0; i < 3; i++) begin
            // two real writes after HALT, then an idle cycle
            drive(i < 2, 3'b100, 3'b011, 2'd0, 32'h0, 32'h200 + i, 32'h0, 5'(8 + i), 1'b0);
            tick();
            tests_run++; if (halt_done_o !== 1'b1) begin tests_failed++; $display("FAIL post_halt_done[%0d] got %b exp 1", i, halt_done_o); end
            tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL post_halt_rw[%0d] got %b exp 0", i, reg_write_o); end
            tests_run++; if (retired_count_o !== 32'd5) begin tests_failed++; $display("FAIL post_halt_cnt[%0d] got %0d exp 5", i, retired_count_o); end
        end
    endtask

    task automatic test_reset_after_halt();
        drive(1'b1, 3'b100, 3'b011, 2'd0, 32'h0, 32'h7777_7777, 32'h0, 5'd6, 1'b0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        exp_cnt = 0;
        tests_run++; if (reg_write_o !== 1'b0) begin tests_failed++; $display("FAIL rst2_rw got %b exp 0", reg_write_o); end
        tests_run++; if (write_register_o !== 5'd0) begin tests_failed++; $display("FAIL rst2_rd got %0d exp 0", write_register_o); end
        tests_run++; if (data_rw_o !== 32'h0) begin tests_failed++; $display("FAIL rst2_data got %h exp 0", data_rw_o); end
        tests_run++; if (halt_done_o !== 1'b0) begin tests_failed++; $display("FAIL rst2_halt got %b exp 0", halt_done_o); end
        tests_run++; if (retired_count_o !== 32'd0) begin tests_failed++; $display("FAIL rst2_cnt got %0d exp 0", retired_count_o); end
        drive(1'b1, 3'b100, 3'b011, 2'd0, 32'h0, 32'h0000_CAFE, 32'h0, 5'd3, 1'b0);
        tick();
        tests_run++; if (reg_write_o !== 1'b1) begin tests_failed++; $display("FAIL rst2_wr_rw got %b exp 1", reg_write_o); end
        tests_run++; if (write_register_o !== 5'd3) begin tests_failed++; $display("FAIL rst2_wr_rd got %0d exp 3", write_register_o); end
        tests_run++; if (data_rw_o !== 32'h0000_CAFE) begin tests_failed++; $display("FAIL rst2_wr_data got %h exp 0000cafe", data_rw_o); end
        tests_run++; if (retired_count_o !== 32'd1) begin tests_failed++; $display("FAIL rst2_wr_cnt got %0d exp 1", retired_count_o); end
    endtask

    initial begin
        exp_cnt = 0;
        test_reset();
        test_load_byte();
        test_load_half();
        test_load_word();
        test_link();
        test_flush();
        test_hold();
        test_halt_stream();
        test_reset_after_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
